// File: rtl/stream_mux_pkg.sv
// Shared types for the registered round-robin / direct-select stream mux.
package stream_mux_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin priority search: first requesting channel at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              en,
  output logic              gnt_valid,
  output logic [SEL_W-1:0]  gnt_idx
);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      int unsigned c;
      c = 32'(ptr) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (en && !gnt_valid && req[c]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream mux with chip select, direct or round-robin grant, and a registered output stage.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      cs,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_CH-1:0]         in_valid,
  input  logic [NUM_CH*WIDTH-1:0]   in_data,
  output logic [NUM_CH-1:0]         in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  input  logic                      out_ready
);

  localparam logic [SEL_W:0] NUM_CH_EXT = (SEL_W+1)'(NUM_CH);

  out_state_e         state_q;
  logic [WIDTH-1:0]   data_q;
  logic [SEL_W-1:0]   ch_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [SEL_W-1:0]   ptr_d;

  mode_e              mode_sel;
  logic               can_load;
  logic               sel_ok;
  logic               rr_gnt_valid;
  logic [SEL_W-1:0]   rr_gnt_idx;
  logic               load;
  logic [SEL_W-1:0]   load_idx;
  logic [WIDTH-1:0]   load_data;

  assign mode_sel  = mode_e'(mode);
  assign out_valid = (state_q == OUT_FULL);
  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign can_load  = !out_valid || out_ready;
  assign sel_ok    = ({1'b0, sel} < NUM_CH_EXT);

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .en        (cs && (mode_sel == MODE_RR)),
    .gnt_valid (rr_gnt_valid),
    .gnt_idx   (rr_gnt_idx)
  );

  // Direct-mode ready is driven from sel alone so it never waits on in_valid;
  // the actual load still requires the valid/ready handshake.
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (nreset && cs && can_load) begin
        if (mode_sel == MODE_DIRECT)
          in_ready[i] = sel_ok && (sel == SEL_W'(i));
        else
          in_ready[i] = rr_gnt_valid && (rr_gnt_idx == SEL_W'(i));
      end
    end
  end

  always_comb begin
    load_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (in_ready[i]) load_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign load     = |(in_valid & in_ready);
  assign load_idx = (mode_sel == MODE_RR) ? rr_gnt_idx : sel;
  assign ptr_d    = (load_idx == SEL_W'(NUM_CH-1)) ? '0 : load_idx + 1'b1;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      if (load) begin
        state_q <= OUT_FULL;
        data_q  <= load_data;
        ch_q    <= load_idx;
        if (mode_sel == MODE_RR) ptr_q <= ptr_d;
      end else if (out_valid && out_ready) begin
        state_q <= OUT_EMPTY;
        data_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed scenarios plus random traffic against a behavioural model.
module tb_stream_mux_rr;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int SEL_W  = $clog2(NUM_CH);

  logic                    clk;
  logic                    nreset;
  logic                    cs;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_ready;

  stream_mux_rr #(
    .NUM_CH (NUM_CH),
    .WIDTH  (WIDTH)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .cs        (cs),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: the held beat and the round-robin start point.
  logic       m_valid;
  logic [7:0] m_data;
  int         m_ch;
  int         m_ptr;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [NUM_CH-1:0] model_ready();
    logic [NUM_CH-1:0] r;
    int found;
    r = '0;
    found = -1;
    if (nreset && cs && (!m_valid || out_ready)) begin
      if (!mode) begin
        if (int'(sel) < NUM_CH) r[sel] = 1'b1;
      end else begin
        for (int k = 0; k < NUM_CH; k++) begin
          int c;
          c = (m_ptr + k) % NUM_CH;
          if (found < 0 && in_valid[c]) found = c;
        end
        if (found >= 0) r[found] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = 0;
    m_ptr   = 0;
  endtask

  task automatic set_data(input int ch, input logic [7:0] d);
    in_data[ch*WIDTH +: WIDTH] = d;
  endtask

  // One clock: compare outputs and readies at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    logic [NUM_CH-1:0] er;
    int  gi;
    logic [7:0] gd;
    @(negedge clk);
    if (!nreset) model_reset();
    er = model_ready();
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data",  32'(out_data),  32'(m_data));
    check("out_ch",    32'(out_ch),    32'(m_ch));
    check("in_ready",  32'(in_ready),  32'(er));
    gi = -1;
    gd = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (er[i] && in_valid[i]) begin
        gi = i;
        gd = in_data[i*WIDTH +: WIDTH];
      end
    @(posedge clk);
    #1;
    if (nreset) begin
      if (gi >= 0) begin
        m_valid = 1'b1;
        m_data  = gd;
        m_ch    = gi;
        if (mode) m_ptr = (gi + 1) % NUM_CH;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
        m_data  = '0;
      end
    end else begin
      model_reset();
    end
  endtask

  int rr_seq_a [6] = '{0, 1, 2, 3, 0, 1};
  int rr_seq_b [5] = '{2, 3, 0, 2, 3};

  initial begin
    model_reset();
    nreset = 1'b0; cs = 1'b1; mode = 1'b0; sel = '0;
    in_valid = '1; in_data = '0; out_ready = 1'b1;

    // Reset holds everything idle even with all channels valid.
    repeat (2) cycle();
    check("rst_ready", 32'(in_ready), 32'h0);
    nreset = 1'b1; cs = 1'b0;
    repeat (3) cycle();
    check("cs0_idle", 32'(out_valid), 32'h0);

    // Direct select.
    cs = 1'b1; mode = 1'b0; sel = 2'd2;
    for (int i = 0; i < NUM_CH; i++) set_data(i, 8'(8'h50 + i));
    set_data(2, 8'hA5);
    #1 check("dir_ready", 32'(in_ready), 32'b0100);
    cycle();
    check("dir_data", 32'(out_data), 32'hA5);
    check("dir_ch",   32'(out_ch),   32'd2);
    sel = 2'd3; in_valid = 4'b0111;
    cycle();
    check("dir_idle", 32'(out_valid), 32'h0);

    // Backpressure then release without a bubble.
    sel = 2'd0; in_valid = 4'b0001; set_data(0, 8'h11);
    cycle();
    set_data(0, 8'h22); out_ready = 1'b0;
    repeat (5) cycle();
    check("bp_hold", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    cycle();
    check("bp_next", 32'(out_data), 32'h22);

    // Round-robin fairness, then with channel 1 dropped.
    mode = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < NUM_CH; i++) set_data(i, 8'(8'h10 + i));
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("rr_seq", 32'(out_ch), 32'(rr_seq_a[k]));
    end
    in_valid = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("rr_skip", 32'(out_ch), 32'(rr_seq_b[k]));
    end

    // Chip select dropped while full: beat drains, pointer is kept.
    for (int i = 0; i < NUM_CH; i++) set_data(i, 8'h33);
    cycle();
    check("cs_full", 32'(out_data), 32'h33);
    cs = 1'b0;
    cycle();
    check("cs_drain", 32'(out_valid), 32'h0);
    cycle();
    cs = 1'b1; in_valid = 4'b1111;
    cycle();
    check("cs_resume", 32'(out_ch), 32'd1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      cs        = ($urandom_range(0, 7) != 0);
      mode      = $urandom_range(0, 1);
      sel       = SEL_W'($urandom_range(0, NUM_CH-1));
      in_valid  = NUM_CH'($urandom);
      in_data   = (NUM_CH*WIDTH)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Asynchronous reset while full.
    cs = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; set_data(0, 8'h77); out_ready = 1'b0;
    cycle();
    check("pre_rst", 32'(out_valid), 32'h1);
    #2 nreset = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_data",  32'(out_data),  32'h0);
    model_reset();
    cycle();
    nreset = 1'b1; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    cycle();
    check("rst_ptr", 32'(out_ch), 32'd0);
    repeat (3) cycle();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
